// File: rtl/ling_pkg.sv
// Shared constants and elaboration helpers for the pipelined Ling adder.
package ling_pkg;

  localparam int MODE_BIN = 0;
  localparam int MODE_MOD = 1;

  localparam int NUM_LEGAL_WIDTHS = 3;
  localparam int LEGAL_WIDTHS [NUM_LEGAL_WIDTHS] = '{16, 64, 256};

  function automatic bit width_is_legal(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL_WIDTHS; i++) begin
      if (LEGAL_WIDTHS[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

  // Number of radix-4 prefix levels needed to span the full operand.
  function automatic int levels_of(input int w);
    int n;
    int r;
    n = 0;
    r = w;
    while (r > 1) begin
      r = r / 4;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/ling_level.sv
// One radix-4 recursion level of the Ling prefix tree: each node merges itself
// with the three nodes STEP, 2*STEP and 3*STEP below it (wrapping in modulo mode).
module ling_level
  import ling_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEVEL = 0,
  parameter int MODE  = MODE_BIN
) (
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] q_out
);

  localparam int STEP = 4 ** LEVEL;

  for (genvar i = 0; i < WIDTH; i++) begin : g_node
    logic [3:0] dn;
    logic [3:0] qn;

    // Taps below bit 0 wrap around for end-around carry, else act as identity.
    for (genvar j = 0; j < 4; j++) begin : g_tap
      localparam int RAW = i - j * STEP;
      if (RAW >= 0) begin : g_in
        assign dn[j] = d_in[RAW];
        assign qn[j] = q_in[RAW];
      end else if (MODE == MODE_MOD) begin : g_wrap
        assign dn[j] = d_in[RAW + WIDTH];
        assign qn[j] = q_in[RAW + WIDTH];
      end else begin : g_pad
        assign dn[j] = 1'b0;
        assign qn[j] = 1'b1;
      end
    end

    assign d_out[i] = dn[0]
                    | (qn[0] & dn[1])
                    | (qn[0] & qn[1] & dn[2])
                    | (qn[0] & qn[1] & qn[2] & dn[3]);
    assign q_out[i] = &qn;
  end

endmodule

// File: rtl/ling_adder_pipe.sv
// Pipelined radix-4 Ling adder, binary or modulo 2^WIDTH-1, with a global stall.
// Defining LING_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module ling_adder_pipe
  import ling_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = MODE_BIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef LING_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LEVELS = levels_of(WIDTH);

  if (!width_is_legal(WIDTH)) begin : g_bad_width
    $error("ling_adder_pipe: WIDTH %0d must be 16, 64 or 256", WIDTH);
  end
  if (MODE != MODE_BIN && MODE != MODE_MOD) begin : g_bad_mode
    $error("ling_adder_pipe: MODE %0d must be 0 or 1", MODE);
  end

  logic             st_valid [LEVELS];
  logic [WIDTH-1:0] st_d     [LEVELS];
  logic [WIDTH-1:0] st_q     [LEVELS];
  logic [WIDTH-1:0] st_p     [LEVELS];
  logic [WIDTH-1:0] st_x     [LEVELS];
  logic             st_cin   [LEVELS];
  logic [WIDTH-1:0] lvl_d    [LEVELS];
  logic [WIDTH-1:0] lvl_q    [LEVELS];

  logic [WIDTH-1:0] bit_g, bit_p, bit_x, bit_q;
  logic             bit_cin;
  logic [WIDTH-1:0] fin_h, fin_c, fin_sum;
  logic             fin_c0;

  assign in_ready = out_ready | ~out_valid;

  // Ling nodes pair g_i with p_(i-1); bit 0 sees either the carry-in slot or p of the top bit.
  assign bit_g   = a & b;
  assign bit_p   = a | b;
  assign bit_x   = a ^ b;
  assign bit_q   = {bit_p[WIDTH-2:0], (MODE == MODE_MOD) ? bit_p[WIDTH-1] : 1'b1};
  assign bit_cin = (MODE == MODE_BIN) ? cin : 1'b0;

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    ling_level #(
      .WIDTH(WIDTH),
      .LEVEL(l),
      .MODE (MODE)
    ) u_level (
      .d_in (st_d[l]),
      .q_in (st_q[l]),
      .d_out(lvl_d[l]),
      .q_out(lvl_q[l])
    );
  end

  // Real carries are p_i & H_i; the sum bit takes the carry from the bit below.
  assign fin_h   = lvl_d[LEVELS-1] | (lvl_q[LEVELS-1] & {WIDTH{st_cin[LEVELS-1]}});
  assign fin_c   = st_p[LEVELS-1] & fin_h;
  assign fin_c0  = (MODE == MODE_MOD) ? fin_c[WIDTH-1] : st_cin[LEVELS-1];
  assign fin_sum = st_x[LEVELS-1] ^ {fin_c[WIDTH-2:0], fin_c0};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LEVELS; s++) st_valid[s] <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef LING_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (in_ready) begin
      st_valid[0] <= in_valid;
      st_d[0]     <= bit_g;
      st_q[0]     <= bit_q;
      st_p[0]     <= bit_p;
      st_x[0]     <= bit_x;
      st_cin[0]   <= bit_cin;
      for (int s = 1; s < LEVELS; s++) begin
        st_valid[s] <= st_valid[s-1];
        st_d[s]     <= lvl_d[s-1];
        st_q[s]     <= lvl_q[s-1];
        st_p[s]     <= st_p[s-1];
        st_x[s]     <= st_x[s-1];
        st_cin[s]   <= st_cin[s-1];
      end
      out_valid <= st_valid[LEVELS-1];
      if (st_valid[LEVELS-1]) begin
        sum  <= fin_sum;
        cout <= (MODE == MODE_BIN) & fin_c[WIDTH-1];
`ifdef LING_ADDER_OVF_EN
        ovf  <= (MODE == MODE_BIN) & (fin_c[WIDTH-1] ^ fin_c[WIDTH-2]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_ling_adder_pipe.sv
// Self-checking bench for ling_adder_pipe: 16-bit binary, 16-bit modulo and 64-bit binary instances.
module tb_ling_adder_pipe;

  logic clk;
  logic rst;

  logic        iv16, ir16, ov16, or16, cin16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        ivm, irm, ovm, orm, cinm, coutm;
  logic [15:0] am, bm, summ;
  logic        iv64, ir64, ov64, or64, cin64, cout64;
  logic [63:0] a64, b64, sum64;
`ifdef LING_ADDER_OVF_EN
  logic        ovf16, ovfm, ovf64;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ling_adder_pipe #(.WIDTH(16), .MODE(0)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16)
`ifdef LING_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  ling_adder_pipe #(.WIDTH(16), .MODE(1)) dutm (
    .clk(clk), .rst(rst), .in_valid(ivm), .in_ready(irm), .a(am), .b(bm), .cin(cinm),
    .out_valid(ovm), .out_ready(orm), .sum(summ), .cout(coutm)
`ifdef LING_ADDER_OVF_EN
    , .ovf(ovfm)
`endif
  );

  ling_adder_pipe #(.WIDTH(64), .MODE(0)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64), .cin(cin64),
    .out_valid(ov64), .out_ready(or64), .sum(sum64), .cout(cout64)
`ifdef LING_ADDER_OVF_EN
    , .ovf(ovf64)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [15:0] va, input logic [15:0] vb,
                               input logic vc);
    if (which == 0) begin
      a16 = va; b16 = vb; cin16 = vc; iv16 = 1'b1;
    end else begin
      am = va; bm = vb; cinm = vc; ivm = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    ivm  = 1'b0;
  endtask

  task automatic waitValid(input int which, output int n);
    n = 1;
    while (((which == 0) ? !ov16 : !ovm) && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [15:0] modAdd(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[15:0] + 16'(s[16]);
  endfunction

  task automatic feedThree(output logic [16:0] r [3]);
    logic [15:0] sa, sb;
    logic        sc;
    for (int k = 0; k < 3; k++) begin
      sa = 16'($urandom); sb = 16'($urandom); sc = 1'($urandom);
      a16 = sa; b16 = sb; cin16 = sc; iv16 = 1'b1;
      r[k] = {1'b0, sa} + {1'b0, sb} + 17'(sc);
      @(negedge clk);
    end
    iv16 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        bin_vecs [10];
    vec_t        mod_vecs [7];
    logic [16:0] exp_r [3];
    logic [64:0] q64 [$];
    logic [15:0] qm [$];
    logic [64:0] e64;
    logic [15:0] em;
    logic        ready_rule;
    int          n, stray, sent, recv, cyc, got, first, last;

    rst = 1'b1;
    a16 = '0; b16 = '0; cin16 = 1'b0; iv16 = 1'b1; or16 = 1'b1;
    am  = '0; bm  = '0; cinm  = 1'b0; ivm  = 1'b0; orm  = 1'b1;
    a64 = '0; b64 = '0; cin64 = 1'b0; iv64 = 1'b0; or64 = 1'b1;

    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 65'(ov16), 65'd0);
    checkOutput("reset_sum", 65'(sum16), 65'd0);
    checkOutput("reset_cout", 65'(cout16), 65'd0);
    checkOutput("reset_in_ready", 65'(ir16), 65'd1);
    checkOutput("reset_out_valid_mod", 65'(ovm), 65'd0);
    checkOutput("reset_out_valid_64", 65'(ov64), 65'd0);
    @(negedge clk);
    rst  = 1'b0;
    iv16 = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (ov16) stray++;
    end
    checkOutput("reset_input_ignored", 65'(stray), 65'd0);

    bin_vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    bin_vecs[1] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    bin_vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    bin_vecs[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    bin_vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    bin_vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    bin_vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    bin_vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    bin_vecs[8] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    bin_vecs[9] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};

    mod_vecs[0] = '{16'h8000, 16'h8000, 1'b0, 16'h0001, 1'b0, 1'b0};
    mod_vecs[1] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    mod_vecs[2] = '{16'h0001, 16'h0002, 1'b1, 16'h0003, 1'b0, 1'b0};
    mod_vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0};
    mod_vecs[4] = '{16'hFFFE, 16'h0003, 1'b1, 16'h0002, 1'b0, 1'b0};
    mod_vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
    mod_vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, bin_vecs[i].a, bin_vecs[i].b, bin_vecs[i].cin);
      waitValid(0, n);
      checkOutput($sformatf("bin%0d_latency", i), 65'(n), 65'd3);
      checkOutput($sformatf("bin%0d_result", i), 65'({cout16, sum16}),
                  65'({bin_vecs[i].co, bin_vecs[i].s}));
`ifdef LING_ADDER_OVF_EN
      checkOutput($sformatf("bin%0d_ovf", i), 65'(ovf16), 65'(bin_vecs[i].ovf));
`endif
    end
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, mod_vecs[i].a, mod_vecs[i].b, mod_vecs[i].cin);
      waitValid(1, n);
      checkOutput($sformatf("mod%0d_latency", i), 65'(n), 65'd3);
      checkOutput($sformatf("mod%0d_result", i), 65'({coutm, summ}), 65'({1'b0, mod_vecs[i].s}));
`ifdef LING_ADDER_OVF_EN
      checkOutput($sformatf("mod%0d_ovf", i), 65'(ovfm), 65'd0);
`endif
    end
    @(negedge clk);

    got = 0; first = -1; last = -1;
    for (int c = 0; c < 230; c++) begin
      if (ovm) begin
        if (qm.size() == 0) begin
          checkOutput("mod_stream_extra", 65'd1, 65'd0);
        end else begin
          em = qm.pop_front();
          checkOutput("mod_stream_sum", 65'(summ), 65'(em));
          got++;
          if (first < 0) first = c;
          last = c;
        end
      end
      if (c < 200) begin
        am = 16'($urandom); bm = 16'($urandom); cinm = 1'($urandom); ivm = 1'b1;
        qm.push_back(modAdd(am, bm));
      end else begin
        ivm = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("mod_stream_count", 65'(got), 65'd200);
    checkOutput("mod_stream_back_to_back", 65'(last - first), 65'd199);

    or16 = 1'b0;
    feedThree(exp_r);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_in_ready", 65'(ir16), 65'd0);
      checkOutput("stall_hold", 65'({ov16, cout16, sum16}), 65'({1'b1, exp_r[0]}));
      @(negedge clk);
    end
    or16 = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("release_result%0d", k), 65'({ov16, cout16, sum16}),
                  65'({1'b1, exp_r[k]}));
      @(negedge clk);
    end
    checkOutput("release_drained", 65'(ov16), 65'd0);

    or16 = 1'b0;
    feedThree(exp_r);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_out_valid", 65'(ov16), 65'd0);
    checkOutput("midreset_sum", 65'({cout16, sum16}), 65'd0);
    checkOutput("midreset_in_ready", 65'(ir16), 65'd1);
    rst  = 1'b0;
    or16 = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov16) stray++;
    end
    checkOutput("midreset_no_stale", 65'(stray), 65'd0);
    applyStimulus(0, 16'h0001, 16'h0002, 1'b0);
    waitValid(0, n);
    checkOutput("post_reset_latency", 65'(n), 65'd3);
    checkOutput("post_reset_result", 65'({cout16, sum16}), 65'h3);
    @(negedge clk);

    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      if (sent < 1000 && ($urandom % 4) != 0) begin
        iv64 = 1'b1; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; cin64 = 1'($urandom);
      end else begin
        iv64 = 1'b0;
      end
      or64 = 1'($urandom);
      #1;
      ready_rule = or64 | ~ov64;
      checkOutput("rand_in_ready", 65'(ir64), 65'(ready_rule));
      if (ov64 && or64) begin
        if (q64.size() == 0) begin
          checkOutput("rand_extra", 65'd1, 65'd0);
        end else begin
          e64 = q64.pop_front();
          checkOutput("rand_result", {cout64, sum64}, e64);
          recv++;
        end
      end
      if (iv64 && ir64) begin
        q64.push_back({1'b0, a64} + {1'b0, b64} + 65'(cin64));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    iv64 = 1'b0;
    checkOutput("rand_count", 65'(recv), 65'd1000);
    checkOutput("rand_leftover", 65'(q64.size()), 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ling_adder_pipe.md
LING_ADDER_PIPE -- requirements
Module: ling_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values 16, 64, 256 (powers of 4).
REQ-002 SHALL have parameter MODE, default 0; 0 = binary add with carry-in/out, 1 = modulo 2^WIDTH-1 (end-around carry).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in; ignored when MODE=1.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  carry-out (MODE=0); constant 0 when MODE=1.

Function
REQ-014 SHALL compute per-bit g=a&b, p=a|b, x=a^b and form Ling pseudo-carries with radix-4 recursive R/Q/D node groups, LEVELS=log4(WIDTH).
REQ-015 SHALL register after bit-level g/p/x and after each recursion level; latency LAT=LEVELS+1 cycles (16->3, 64->4, 256->5) from accepted input to out_valid.
REQ-016 SHALL accept a transfer when in_valid&in_ready; produce a result when out_valid&out_ready.
REQ-017 SHALL drive in_ready = out_ready | ~out_valid; when low, every pipeline stage holds (global stall, no bubble collapse required).
REQ-018 SHALL carry a valid bit per stage; stages with valid=0 advance without producing output.
REQ-019 SHALL, MODE=0: {cout,sum} = a + b + cin exactly, WIDTH+1 bits.
REQ-020 SHALL, MODE=1: sum = (a+b) mod (2^WIDTH-1) via cyclic prefix wrap (bit 0 uses top-position pseudo-carry); all-ones output (negative zero) is legal and not normalised.
REQ-021 SHALL hold sum/cout stable while out_valid=1 and out_ready=0.
REQ-022 SHALL sustain one result per cycle with out_ready held high.
REQ-023 SHALL drop no result and duplicate no result under any in_valid/out_ready pattern.

Reset
REQ-024 SHALL, while rst=1, clear all stage valid bits; out_valid=0, sum=0, cout=0, in_ready=1 on the cycle after.
REQ-025 SHALL discard all in-flight operations on reset mid-operation; the first accepted input after rst falls yields the first result.
REQ-026 SHALL ignore in_valid during the rst=1 cycle.

Configuration
REQ-027 SHALL, with LING_ADDER_OVF_EN defined, add output ovf (1 bit) = signed two's-complement overflow of the MODE=0 add, registered alongside sum, reset 0, constant 0 when MODE=1.
REQ-028 SHALL, without LING_ADDER_OVF_EN, omit the ovf port and its logic entirely.

Structure
REQ-029 SHALL place MODE encodings (MODE_BIN=0, MODE_MOD=1), legal WIDTH list and a LEVELS-from-WIDTH constant function in shared package ling_pkg.
REQ-030 SHALL implement one radix-4 recursion level as sub-module ling_level (WIDTH, level index, MODE parameters; pure combinational R/Q mapping) instantiated LEVELS times inside generate.
REQ-031 SHALL reject illegal WIDTH/MODE at elaboration.

Verification
REQ-032 WIDTH=16, MODE=0: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, out_valid exactly 3 cycles after accept.
REQ-033 WIDTH=16, MODE=1: a=0x8000, b=0x8000 -> sum=0x0001; a=0xAAAA, b=0x5555 -> sum=0xFFFF.
REQ-034 WIDTH=64, MODE=0: stream 1000 random pairs, out_ready toggling randomly -> results in order, match reference model, none lost.
REQ-035 WIDTH=16: out_ready=0 for 5 cycles with 3 results in flight -> in_ready=0, sum held; release -> 3 results on consecutive cycles.
REQ-036 Reset asserted with pipeline full -> out_valid=0 next cycle, no stale result after rst falls.
REQ-037 LING_ADDER_OVF_EN defined, WIDTH=16, MODE=0: a=0x7FFF, b=0x0001 -> ovf=1, sum=0x8000; a=0xFFFF, b=0x0001 -> ovf=0.
